// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered parametrised ALU with start/busy/done and shift-add multiplier
//
// Purpose: EX-stage ALU. Single-cycle ops (ADD, SUB, AND, OR, SLT, BNE, SLL)
// complete on the start edge. MUL is an unsigned radix-2 shift-add that takes
// WIDTH further edges. All results and flags are registered.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - operation request, sampled only while idle
//   opcod  - operation select (latched with start)
//   X, Y   - operands (latched with start)
//   Cin    - carry-in, ADD only
//   out    - result (low word for MUL)
//   hi     - MUL high word, 0 for other ops
//   Cout   - carry out (ADD/SUB)
//   V      - signed overflow (ADD/SUB), hi!=0 for MUL
//   lt/eq/gt - signed compare of the latched operands
//   busy   - high while MUL iterates
//   done   - one-cycle pulse when results become valid
module alu_seq_param #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcod,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             Cout,
  output logic             V,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   ya;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [31:0]        shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     pp_sum;
  logic [2*WIDTH-1:0] acc_next;

  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
  endfunction

  assign add_sum = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
  assign sub_sum = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
  // Shift amount is reduced modulo WIDTH so non-power-of-two widths wrap too.
  assign shamt   = 32'(Y[SHW-1:0]) % WIDTH;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcod)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (X[WIDTH-1] == Y[WIDTH-1]) && (add_sum[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_sum[WIDTH-1] != X[WIDTH-1]);
      end
      OP_AND:  alu_res = X & Y;
      OP_OR:   alu_res = X | Y;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
      OP_BNE:  alu_res = {{(WIDTH-1){1'b0}}, X != Y};
      OP_SLL:  alu_res = X << shamt;
      default: alu_res = '0;
    endcase
  end

  // Accumulator holds {partial high, remaining multiplier bits}; each step
  // conditionally adds the multiplicand to the top half and shifts right.
  assign pp_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign acc_next = {pp_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      ya    <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      hi    <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (opcod == OP_MUL) begin
              mcand <= X;
              ya    <= Y;
              acc   <= {{WIDTH{1'b0}}, Y};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= MUL;
            end else begin
              out          <= alu_res;
              hi           <= '0;
              Cout         <= alu_c;
              V            <= alu_v;
              {lt, eq, gt} <= cmp3(X, Y);
              done         <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          // Results are written only on the last step so the partial
          // product never reaches out/hi.
          if (cnt == CW'(WIDTH - 1)) begin
            out          <= acc_next[WIDTH-1:0];
            hi           <= acc_next[2*WIDTH-1:WIDTH];
            Cout         <= 1'b0;
            V            <= |acc_next[2*WIDTH-1:WIDTH];
            {lt, eq, gt} <= cmp3(mcand, ya);
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - self-checking bench for alu_seq_param at WIDTH 16 and 8
module tb_alu_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_start, a_cin, a_cout, a_v, a_lt, a_eq, a_gt, a_busy, a_done;
  logic [2:0]  a_op;
  logic [15:0] a_x, a_y, a_out, a_hi;

  logic        b_start, b_cin, b_cout, b_v, b_lt, b_eq, b_gt, b_busy, b_done;
  logic [2:0]  b_op;
  logic [7:0]  b_x, b_y, b_out, b_hi;

  alu_seq_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(a_start), .opcod(a_op), .X(a_x), .Y(a_y), .Cin(a_cin),
    .out(a_out), .hi(a_hi), .Cout(a_cout), .V(a_v), .lt(a_lt), .eq(a_eq), .gt(a_gt),
    .busy(a_busy), .done(a_done));

  alu_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(b_start), .opcod(b_op), .X(b_x), .Y(b_y), .Cin(b_cin),
    .out(b_out), .hi(b_hi), .Cout(b_cout), .V(b_v), .lt(b_lt), .eq(b_eq), .gt(b_gt),
    .busy(b_busy), .done(b_done));

  typedef struct {
    longint out;
    longint hi;
    bit     cout;
    bit     v;
    bit     lt;
    bit     eq;
    bit     gt;
  } res_t;

  typedef struct {
    logic [2:0] op;
    longint     x;
    longint     y;
    bit         cin;
    res_t       e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic res_t model(int w, logic [2:0] op, longint x, longint y, bit cin);
    res_t   r;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sx, sy, s, ss;
    r  = '{default: 0};
    sx = (x >= half) ? x - (longint'(1) << w) : x;
    sy = (y >= half) ? y - (longint'(1) << w) : y;
    case (op)
      3'd0: begin
        s = x + y + longint'(cin); ss = sx + sy + longint'(cin);
        r.out = s & m; r.cout = s[w]; r.v = (ss >= half) || (ss < -half);
      end
      3'd1: begin
        s = x + (~y & m) + 1; ss = sx - sy;
        r.out = s & m; r.cout = s[w]; r.v = (ss >= half) || (ss < -half);
      end
      3'd2: r.out = x & y;
      3'd3: r.out = x | y;
      3'd4: r.out = longint'(sx < sy);
      3'd5: r.out = longint'(x != y);
      3'd6: begin
        s = x * y; r.out = s & m; r.hi = s >> w; r.v = (r.hi != 0);
      end
      default: r.out = (x << (y % w)) & m;
    endcase
    r.lt = (sx < sy); r.eq = (sx == sy); r.gt = (sx > sy);
    return r;
  endfunction

  task automatic drive(int w, bit s, logic [2:0] op, longint x, longint y, bit cin);
    if (w == 16) begin
      a_start = s; a_op = op; a_x = x[15:0]; a_y = y[15:0]; a_cin = cin;
    end else begin
      b_start = s; b_op = op; b_x = x[7:0]; b_y = y[7:0]; b_cin = cin;
    end
  endtask

  function automatic res_t sample(int w);
    res_t r;
    if (w == 16) begin
      r.out = longint'(a_out); r.hi = longint'(a_hi);
      r.cout = a_cout; r.v = a_v; r.lt = a_lt; r.eq = a_eq; r.gt = a_gt;
    end else begin
      r.out = longint'(b_out); r.hi = longint'(b_hi);
      r.cout = b_cout; r.v = b_v; r.lt = b_lt; r.eq = b_eq; r.gt = b_gt;
    end
    return r;
  endfunction

  function automatic bit get_done(int w);
    return (w == 16) ? a_done : b_done;
  endfunction

  function automatic bit get_busy(int w);
    return (w == 16) ? a_busy : b_busy;
  endfunction

  // One operation: start pulse, then operands scrambled while waiting for done.
  task automatic run(int w, logic [2:0] op, longint x, longint y, bit cin,
                     output res_t got, output int bcyc, output bit ok);
    int t = 0;
    @(negedge clk); drive(w, 1'b1, op, x, y, cin);
    @(negedge clk); drive(w, 1'b0, 3'($urandom), longint'($urandom), longint'($urandom), 1'b1);
    bcyc = 0;
    while (!get_done(w) && t < 4 * w) begin
      if (get_busy(w)) bcyc++;
      @(negedge clk); t++;
    end
    ok  = get_done(w);
    got = sample(w);
  endtask

  task automatic cmp_res(string tag, res_t g, res_t e);
    chk({tag, ".out"},  g.out,  e.out);
    chk({tag, ".hi"},   g.hi,   e.hi);
    chk({tag, ".Cout"}, longint'(g.cout), longint'(e.cout));
    chk({tag, ".V"},    longint'(g.v),    longint'(e.v));
    chk({tag, ".lt"},   longint'(g.lt),   longint'(e.lt));
    chk({tag, ".eq"},   longint'(g.eq),   longint'(e.eq));
    chk({tag, ".gt"},   longint'(g.gt),   longint'(e.gt));
  endtask

  task automatic check_model(string tag, int w, logic [2:0] op, longint x, longint y, bit cin);
    res_t g, e;
    int   bc;
    bit   ok;
    run(w, op, x, y, cin, g, bc, ok);
    e = model(w, op, x, y, cin);
    chk({tag, ".done"}, longint'(ok), 1);
    cmp_res(tag, g, e);
    chk({tag, ".busy_cycles"}, longint'(bc), (op == 3'd6) ? longint'(w) : 0);
  endtask

  vec_t tbl[12];

  initial begin
    res_t g, e;
    int   bc, dones, busy_n, done_at;
    bit   ok;
    logic [2:0] bops[4];
    longint bx[4], by[4];

    tbl[0]  = '{3'd0, 'h7FFF, 'h0001, 1'b0, '{'h8000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[1]  = '{3'd0, 'hFFFF, 'h0001, 1'b1, '{'h0001, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2]  = '{3'd1, 'h0003, 'h0005, 1'b0, '{'hFFFE, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[3]  = '{3'd4, 'hFFFF, 'h0001, 1'b0, '{'h0001, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[4]  = '{3'd5, 'h1234, 'h1234, 1'b0, '{'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[5]  = '{3'd7, 'h0001, 'h0013, 1'b0, '{'h0008, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{3'd2, 'hF0F0, 'h0FF0, 1'b0, '{'h00F0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[7]  = '{3'd3, 'hF0F0, 'h0FF0, 1'b0, '{'hFFF0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[8]  = '{3'd6, 'hFFFF, 'hFFFF, 1'b0, '{'h0001, 'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{3'd1, 'h8000, 'h0001, 1'b1, '{'h7FFF, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[10] = '{3'd7, 'hABCD, 'h0010, 1'b0, '{'hABCD, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{3'd0, 'h8000, 'h8000, 1'b0, '{'h0000, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst = 1'b1;
    drive(16, 1'b0, 3'd0, 0, 0, 1'b0);
    drive(8, 1'b0, 3'd0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset.w16", longint'({a_out, a_hi, a_cout, a_v, a_lt, a_eq, a_gt, a_busy, a_done}), 0);
    chk("reset.w8",  longint'({b_out, b_hi, b_cout, b_v, b_lt, b_eq, b_gt, b_busy, b_done}), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run(16, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].cin, g, bc, ok);
      chk($sformatf("vec%0d.done", i), longint'(ok), 1);
      cmp_res($sformatf("vec%0d", i), g, tbl[i].e);
      if (tbl[i].op == 3'd6) chk($sformatf("vec%0d.busy_cycles", i), longint'(bc), 16);
    end

    // MUL latency, result hold during busy, start pulse during busy ignored.
    check_model("pre_mul_add", 16, 3'd0, 5, 6, 1'b0);
    @(negedge clk); drive(16, 1'b1, 3'd6, 'hFFFF, 'hFFFF, 1'b0);
    @(negedge clk);
    dones = 0; busy_n = 0; done_at = -1;
    for (int i = 0; i < 22; i++) begin
      if (a_busy) busy_n++;
      if (a_done) begin
        dones++; done_at = i; g = sample(16);
      end
      if (i == 7) chk("mul_hold.out_hi", longint'({a_hi, a_out}), 'h0000_000B);
      if (i == 4) drive(16, 1'b1, 3'd0, 1, 1, 1'b0);
      else        drive(16, 1'b0, 3'd0, 1, 1, 1'b0);
      @(negedge clk);
    end
    chk("mul16.busy_cycles", longint'(busy_n), 16);
    chk("mul16.done_count", longint'(dones), 1);
    chk("mul16.done_cycle", longint'(done_at), 16);
    cmp_res("mul16", g, model(16, 3'd6, 'hFFFF, 'hFFFF, 1'b0));

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk); drive(16, 1'b1, 3'd6, 'h00FF, 'h0101, 1'b0);
    @(negedge clk); drive(16, 1'b0, 3'd0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_mul.outputs", longint'({a_out, a_hi, a_cout, a_v, a_lt, a_eq, a_gt, a_busy, a_done}), 0);
    @(negedge clk); rst = 1'b0;
    check_model("post_rst_add", 16, 3'd0, 1, 1, 1'b0);
    chk("post_rst_add.out", longint'(a_out), 2);

    // Back-to-back single-cycle ops with start held high.
    bops = '{3'd0, 3'd1, 3'd2, 3'd3};
    foreach (bops[i]) begin
      bx[i] = longint'($urandom_range(0, 65535));
      by[i] = longint'($urandom_range(0, 65535));
    end
    @(negedge clk); drive(16, 1'b1, bops[0], bx[0], by[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d.done", i), longint'(a_done), 1);
      cmp_res($sformatf("b2b%0d", i), sample(16), model(16, bops[i], bx[i], by[i], 1'b0));
      if (i < 3) drive(16, 1'b1, bops[i+1], bx[i+1], by[i+1], 1'b0);
      else       drive(16, 1'b0, 3'd0, 0, 0, 1'b0);
    end
    @(negedge clk);
    chk("b2b.done_falls", longint'(a_done), 0);

    // WIDTH=8: MUL takes 8 cycles; start held through busy is taken only after done.
    check_model("mul8_max", 8, 3'd6, 'hFF, 'hFF, 1'b0);
    @(negedge clk); drive(8, 1'b1, 3'd6, 'hB7, 'h5D, 1'b0);
    @(negedge clk); drive(8, 1'b1, 3'd0, 3, 4, 1'b0);
    busy_n = 0;
    for (int t = 0; t < 40 && !b_done; t++) begin
      if (b_busy) busy_n++;
      @(negedge clk);
    end
    chk("mul8_held.busy_cycles", longint'(busy_n), 8);
    chk("mul8_held.done", longint'(b_done), 1);
    cmp_res("mul8_held", sample(8), model(8, 3'd6, 'hB7, 'h5D, 1'b0));
    @(negedge clk); drive(8, 1'b0, 3'd0, 0, 0, 1'b0);
    chk("mul8_held.next_done", longint'(b_done), 1);
    cmp_res("mul8_held_add", sample(8), model(8, 3'd0, 3, 4, 1'b0));

    // Randomised ops against the reference model at both widths.
    for (int i = 0; i < 120; i++) begin
      logic [2:0] op;
      longint x, y;
      bit c;
      op = 3'($urandom_range(0, 7));
      x = longint'($urandom_range(0, 65535));
      y = longint'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      if (i % 4 == 0) y = x;
      check_model($sformatf("rnd16_%0d op%0d x%0h y%0h c%0d", i, op, x, y, c), 16, op, x, y, c);
      check_model($sformatf("rnd8_%0d op%0d x%0h y%0h c%0d", i, op, x & 'hFF, y & 'hFF, c),
                  8, op, x & 'hFF, y & 'hFF, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, registered successor to the 16-bit datapath ALU, sitting in the EX stage of the pipelined datapath.
- Width is generic.
- Every result and flag is registered, and the block has a start/busy/done handshake.
- Adds SUB, SLT, a real branch-not-equal flag, shift-left and a multi-cycle shift-add multiplier with a high-word output.

Parameters:
- WIDTH, 16, operand/result width in bits; minimum 4.
- SHW, $clog2(WIDTH), shift-amount bits taken from Y[SHW-1:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only when busy=0.
- opcod  input  3  operation select, latched with start.
- X  input  WIDTH  operand A, latched with start.
- Y  input  WIDTH  operand B, latched with start.
- Cin  input  1  carry-in, used only by ADD.
- out  output  WIDTH  registered result (low word for MUL).
- hi  output  WIDTH  registered MUL high word; 0 for all other ops.
- Cout  output  1  registered carry out (ADD/SUB).
- V  output  1  registered signed overflow.
- lt  output  1  registered signed X<Y.
- eq  output  1  registered X==Y.
- gt  output  1  registered signed X>Y.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse when out/hi/flags become valid.

Behaviour:
- Reset (async, any time, including mid-MUL):
  - out=0, hi=0, Cout=0, V=0, lt=0, eq=0, gt=0, busy=0, done=0.
  - FSM returns to IDLE; the multiplier accumulator and counter clear.
- FSM states: IDLE, MUL.
- IDLE with start=1 on edge k:
  - 000 ADD: {Cout,out} = X+Y+Cin; V = signed overflow.
  - 001 SUB: {Cout,out} = X+~Y+1 (Cin ignored); Cout=1 means no borrow; V = signed overflow.
  - 010 AND: out = X&Y.
  - 011 OR: out = X|Y.
  - 100 SLT: out = {0..0, signed X<Y}.
  - 101 BNE: out = {0..0, X!=Y}.
  - 110 MUL: go to MUL (see below).
  - 111 SLL: out = X << Y[SHW-1:0]; shift amount is taken modulo WIDTH.
  - For every op except MUL:
    - Registers update on edge k; done=1 for the single cycle after edge k; FSM stays in IDLE; latency 1.
    - Cout and V are 0 for ops other than ADD/SUB.
    - hi=0.
- Flags for every op:
  - lt/eq/gt are computed from the latched operands.
  - Signed two's-complement compare.
  - Exactly one of lt/eq/gt is high after each done.
- MUL (unsigned, radix-2 shift-add):
  - Edge k latches X and Y, clears the 2*WIDTH accumulator and counter, and sets busy=1.
  - Each following edge processes one multiplier bit.
  - After WIDTH iterations (edge k+WIDTH): {hi,out} = X*Y, busy falls, done pulses for one cycle, FSM returns to IDLE.
  - Flags: Cout=0; V = (hi!=0).
  - out/hi hold their previous values until that final edge; the partial product is never exposed.
- start while busy=1 is ignored; operands are not re-latched.
- start on the same edge busy falls is ignored. The earliest accepted new start is the edge after done.
- Back-to-back single-cycle ops with start held high are accepted every cycle; done stays high continuously.
- Outputs hold their values between operations. done=0 does not clear results.
- opcod and X/Y changes while not starting have no effect.

Test Plan:
- Reset mid-MUL: start MUL X=16'h00FF Y=16'h0101, assert rst at cycle 5 -> all outputs 0 immediately (async), busy=0. After release, ADD 1+1 Cin=0 -> out=2 one edge later.
- ADD overflow/carry: X=16'h7FFF, Y=16'h0001, Cin=0 -> out=16'h8000, V=1, Cout=0, gt=1. Then X=16'hFFFF, Y=1, Cin=1 -> out=16'h0001, Cout=1, V=0.
- SUB/SLT signed: SUB X=3 Y=5 -> out=16'hFFFE, Cout=0, lt=1. SLT X=16'hFFFF (-1) Y=1 -> out=1, lt=1. BNE X=Y=16'h1234 -> out=0, eq=1.
- MUL latency: X=16'hFFFF Y=16'hFFFF -> busy high for exactly 16 cycles; done after edge k+16 with hi=16'hFFFE, out=16'h0001, V=1. A start pulsed during busy produces no extra done.
- SLL and logic: SLL X=16'h0001 Y=16'h0013 -> out=16'h0008 (shift 19 mod 16 = 3). AND 16'hF0F0 & 16'h0FF0 -> 16'h00F0; OR -> 16'hFFF0.
- Back-to-back: start held high for 4 cycles with ADD, SUB, AND, OR -> done high 4 consecutive cycles with the correct result each edge; rerun at WIDTH=8 and confirm MUL takes 8 cycles.
